// File: rtl/fp_pkg.sv
// Shared field-arithmetic constants and the integer-multiplier state encoding.
package fp_pkg;

  localparam int unsigned FP_W       = 255;
  localparam int unsigned DIGIT_W    = 64;
  localparam int unsigned NUM_DIGITS = (FP_W + DIGIT_W - 1) / DIGIT_W;
  localparam int unsigned PROD_W     = 2 * FP_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage : fp_pkg

// File: rtl/mul_255x64.sv
// Combinational operand-by-digit partial product, reused once per multiply cycle.
module mul_255x64
  import fp_pkg::*;
#(
  parameter int unsigned A_W = FP_W,
  parameter int unsigned B_W = DIGIT_W
) (
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] p_c
);

  localparam int unsigned P_W = A_W + B_W;

  assign p_c = P_W'(a) * P_W'(b);

endmodule : mul_255x64

// File: rtl/fp_intmul.sv
// Digit-serial full-width integer multiplier: one DIGIT_W slice of B per cycle,
// shift-and-add into a double-width accumulator, registered product on done.
module fp_intmul
  import fp_pkg::*;
#(
  parameter int unsigned FP_W       = fp_pkg::FP_W,
  parameter int unsigned DIGIT_W    = fp_pkg::DIGIT_W,
  parameter int unsigned NUM_DIGITS = fp_pkg::NUM_DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FP_W-1:0]   A,
  input  logic [FP_W-1:0]   B,
  output logic              busy,
  output logic              done,
  output logic [2*FP_W-1:0] P
);

  localparam int unsigned ACC_W = 2 * FP_W;
  localparam int unsigned PPR_W = FP_W + DIGIT_W;
  localparam int unsigned BEX_W = NUM_DIGITS * DIGIT_W;
  localparam int unsigned CNT_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FP_W-1:0]   a_q, a_d;
  logic [FP_W-1:0]   b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  p_q, p_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [BEX_W-1:0]   b_ext_c;
  logic [DIGIT_W-1:0] digit_c;
  logic [PPR_W-1:0]   pp_c;
  logic [ACC_W-1:0]   pp_sh_c;
  logic [ACC_W-1:0]   sum_c;

  // Top digit is zero-extended by widening B before slicing.
  assign b_ext_c = BEX_W'(b_q);
  assign digit_c = b_ext_c[32'(cnt_q) * DIGIT_W +: DIGIT_W];

  mul_255x64 #(
    .A_W (FP_W),
    .B_W (DIGIT_W)
  ) u_mul (
    .a   (a_q),
    .b   (digit_c),
    .p_c (pp_c)
  );

  assign pp_sh_c = ACC_W'(pp_c) << (32'(cnt_q) * DIGIT_W);
  assign sum_c   = acc_q + pp_sh_c;

  // Next-state: accept in IDLE, or on the final digit edge to keep 4-cycle throughput.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
          busy_d  = 1'b1;
        end
      end
      MUL: begin
        if (cnt_q == LAST_DIGIT) begin
          p_d    = sum_c;
          done_d = 1'b1;
          acc_d  = '0;
          cnt_d  = '0;
          if (start) begin
            a_d     = A;
            b_d     = B;
            state_d = MUL;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          acc_d = sum_c;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;

endmodule : fp_intmul
